// File: rtl/char_motion_ctl.sv
// Per-frame player movement: synchronised buttons drive horizontal walking with edge clamping
// and a ground/rise/fall jump state machine. Every position, velocity and state bit is registered.
module char_motion_ctl #(
  parameter int HOR_PIXELS    = 1024,
  parameter int VER_PIXELS    = 768,
  parameter int GROUND_MARGIN = 20,
  parameter int CHAR_HGT_RST  = 32,
  parameter int MOVE_STEP     = 4,
  parameter int JUMP_V0       = 12,
  parameter int GRAVITY       = 1,
  parameter int MAX_FALL      = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  input  logic [11:0] char_hgt,
  input  logic [11:0] char_lng,
  output logic [11:0] pos_x,
  output logic [11:0] pos_y,
  output logic        on_ground,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    GROUND = 2'b00,
    RISE   = 2'b01,
    FALL   = 2'b10,
    UNUSED = 2'b11
  } state_t;

  localparam logic signed [12:0] HOR_MAX     = 13'(HOR_PIXELS - 1);
  localparam logic signed [12:0] GROUND_BASE = 13'(VER_PIXELS - GROUND_MARGIN);
  localparam logic signed [12:0] STEP        = 13'(MOVE_STEP);
  localparam logic signed [12:0] GRAV        = 13'(GRAVITY);
  localparam logic signed [12:0] MAXF        = 13'(MAX_FALL);
  localparam logic [11:0]        X_RST       = 12'(HOR_PIXELS / 2);
  localparam logic [11:0]        Y_RST       = 12'(VER_PIXELS - GROUND_MARGIN - CHAR_HGT_RST);

  state_t      cur_state, nxt_state;
  logic [11:0] vel_up, vel_fall, nxt_vu, nxt_vf, nxt_x, nxt_y;
  logic        jump_pending;
  logic        left_s1, left_s2, right_s1, right_s2, jump_s1, jump_s2, jump_s3;

  logic signed [12:0] x_cur, x_move, x_lo, x_hi, step_val;
  logic signed [12:0] y_cur, hgt, ground_y, vu, vf, y_up, y_down, vu_dec, vf_inc;

  assign state = cur_state;

  // Button synchronisers plus one extra jump stage for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      left_s1  <= 1'b0;
      left_s2  <= 1'b0;
      right_s1 <= 1'b0;
      right_s2 <= 1'b0;
      jump_s1  <= 1'b0;
      jump_s2  <= 1'b0;
      jump_s3  <= 1'b0;
    end else begin
      left_s1  <= btn_left;
      left_s2  <= left_s1;
      right_s1 <= btn_right;
      right_s2 <= right_s1;
      jump_s1  <= btn_jump;
      jump_s2  <= jump_s1;
      jump_s3  <= jump_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state    <= GROUND;
      on_ground    <= 1'b1;
      pos_x        <= X_RST;
      pos_y        <= Y_RST;
      vel_up       <= '0;
      vel_fall     <= '0;
      jump_pending <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      on_ground <= (nxt_state == GROUND);
      pos_x     <= nxt_x;
      pos_y     <= nxt_y;
      vel_up    <= nxt_vu;
      vel_fall  <= nxt_vf;
      // A jump request lives only until the next frame; it is never carried over
      if (frame_tick)
        jump_pending <= 1'b0;
      else if (jump_s2 && !jump_s3)
        jump_pending <= 1'b1;
    end
  end

  always_comb begin
    x_cur    = $signed({1'b0, pos_x});
    y_cur    = $signed({1'b0, pos_y});
    hgt      = $signed({1'b0, char_hgt});
    x_lo     = $signed({1'b0, char_lng});
    x_hi     = HOR_MAX - x_lo;
    vu       = $signed({1'b0, vel_up});
    vf       = $signed({1'b0, vel_fall});
    ground_y = GROUND_BASE - hgt;
    y_up     = y_cur - vu;
    y_down   = y_cur + vf;
    vu_dec   = vu - GRAV;
    vf_inc   = vf + GRAV;

    step_val = '0;
    if (right_s2 && !left_s2)
      step_val = STEP;
    else if (left_s2 && !right_s2)
      step_val = -STEP;
    x_move = x_cur + step_val;

    nxt_state = cur_state;
    nxt_x     = pos_x;
    nxt_y     = pos_y;
    nxt_vu    = vel_up;
    nxt_vf    = vel_fall;

    if (frame_tick) begin
      if (x_move < x_lo)
        nxt_x = x_lo[11:0];
      else if (x_move > x_hi)
        nxt_x = x_hi[11:0];
      else
        nxt_x = x_move[11:0];

      case (cur_state)
        GROUND: begin
          nxt_y = ground_y[11:0];
          if (jump_pending) begin
            nxt_vu    = 12'(JUMP_V0);
            nxt_state = RISE;
          end
        end
        RISE: begin
          // Ceiling hit kills the remaining upward speed immediately
          if (y_up < hgt) begin
            nxt_y     = char_hgt;
            nxt_vu    = '0;
            nxt_vf    = GRAV[11:0];
            nxt_state = FALL;
          end else begin
            nxt_y = y_up[11:0];
            if (vu_dec <= 0) begin
              nxt_vu    = '0;
              nxt_vf    = GRAV[11:0];
              nxt_state = FALL;
            end else begin
              nxt_vu = vu_dec[11:0];
            end
          end
        end
        FALL: begin
          if (y_down >= ground_y) begin
            nxt_y     = ground_y[11:0];
            nxt_vf    = '0;
            nxt_state = GROUND;
          end else begin
            nxt_y  = y_down[11:0];
            nxt_vf = (vf_inc > MAXF) ? MAXF[11:0] : vf_inc[11:0];
          end
        end
        default: nxt_state = FALL;
      endcase
    end
  end

endmodule

// File: tb/tb_char_motion_ctl.sv
// Directed bench for char_motion_ctl: reset, walking and clamping, one full jump arc,
// jump-button abuse, and reset in mid-rise.
module tb_char_motion_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        btn_left, btn_right, btn_jump;
  logic [11:0] char_hgt, char_lng;
  logic [11:0] pos_x, pos_y;
  logic        on_ground;
  logic [1:0]  state;

  int errorCount = 0;
  int checkCount = 0;

  char_motion_ctl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .char_hgt(char_hgt), .char_lng(char_lng),
    .pos_x(pos_x), .pos_y(pos_y), .on_ground(on_ground), .state(state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Set buttons and give the synchronisers and edge detector time to settle
  task automatic applyStimulus(input logic left, input logic right, input logic jump);
    @(negedge clk);
    btn_left  = left;
    btn_right = right;
    btn_jump  = jump;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulseTick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic jumpPulse();
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int riseCnt, fallCnt, minY, minX, maxX, groundBad;
    rst = 1'b1; frame_tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    char_hgt = 12'd32; char_lng = 12'd25;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_x", pos_x, 512);
    checkOutput("rst_y", pos_y, 716);
    checkOutput("rst_state", state, 0);
    checkOutput("rst_ground", on_ground, 1);
    repeat (10) @(negedge clk);
    checkOutput("idle_x", pos_x, 512);
    checkOutput("idle_y", pos_y, 716);

    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("presync_x", pos_x, 512);
    for (int i = 1; i <= 3; i++) begin
      pulseTick();
      checkOutput($sformatf("right_%0d", i), pos_x, 512 + 4 * i);
    end
    checkOutput("right_y", pos_y, 716);

    applyStimulus(1'b1, 1'b1, 1'b0);
    pulseTick();
    pulseTick();
    checkOutput("both_x", pos_x, 524);

    applyStimulus(1'b1, 1'b0, 1'b0);
    minX = 4095;
    for (int i = 0; i < 200; i++) begin
      pulseTick();
      if (pos_x < minX) minX = pos_x;
    end
    checkOutput("left_clamp", pos_x, 25);
    checkOutput("left_min", minX, 25);

    applyStimulus(1'b0, 1'b1, 1'b0);
    maxX = 0;
    for (int i = 0; i < 260; i++) begin
      pulseTick();
      if (pos_x > maxX) maxX = pos_x;
    end
    checkOutput("right_clamp", pos_x, 998);
    checkOutput("right_max", maxX, 998);

    // Full jump arc: 1 tick to launch, 12 rising samples, 12 falling, then landed
    applyStimulus(1'b0, 1'b0, 1'b0);
    jumpPulse();
    riseCnt = 0; fallCnt = 0; minY = 4095; groundBad = 0;
    for (int t = 1; t <= 25; t++) begin
      pulseTick();
      if (state == 2'b01) riseCnt++;
      if (state == 2'b10) fallCnt++;
      if (pos_y < minY) minY = pos_y;
      if (t < 25 && on_ground) groundBad++;
      if (t == 1) begin
        checkOutput("launch_state", state, 1);
        checkOutput("launch_y", pos_y, 716);
      end
      if (t == 2) checkOutput("rise1_y", pos_y, 704);
      if (t == 13) begin
        checkOutput("apex_y", pos_y, 638);
        checkOutput("apex_state", state, 2);
      end
    end
    checkOutput("rise_ticks", riseCnt, 12);
    checkOutput("fall_ticks", fallCnt, 12);
    checkOutput("apex_min", minY, 638);
    checkOutput("air_ground_flag", groundBad, 0);
    checkOutput("land_y", pos_y, 716);
    checkOutput("land_state", state, 0);
    checkOutput("land_ground", on_ground, 1);
    checkOutput("jump_x", pos_x, 998);

    // Holding jump past landing must not relaunch
    applyStimulus(1'b0, 1'b0, 1'b1);
    riseCnt = 0;
    for (int t = 1; t <= 35; t++) begin
      pulseTick();
      if (state == 2'b01) riseCnt++;
    end
    checkOutput("held_rise_ticks", riseCnt, 12);
    checkOutput("held_state", state, 0);
    checkOutput("held_y", pos_y, 716);

    // A second press while airborne is discarded
    applyStimulus(1'b0, 1'b0, 1'b0);
    jumpPulse();
    riseCnt = 0;
    for (int t = 1; t <= 5; t++) begin
      pulseTick();
      if (state == 2'b01) riseCnt++;
    end
    jumpPulse();
    for (int t = 6; t <= 35; t++) begin
      pulseTick();
      if (state == 2'b01) riseCnt++;
    end
    checkOutput("midair_rise_ticks", riseCnt, 12);
    checkOutput("midair_state", state, 0);

    // Reset coinciding with a tick in mid-rise
    jumpPulse();
    repeat (4) pulseTick();
    checkOutput("prerst_state", state, 1);
    @(negedge clk);
    rst = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    frame_tick = 1'b0;
    checkOutput("midrst_x", pos_x, 512);
    checkOutput("midrst_y", pos_y, 716);
    checkOutput("midrst_state", state, 0);
    checkOutput("midrst_ground", on_ground, 1);
    pulseTick();
    checkOutput("postrst_y", pos_y, 716);
    checkOutput("postrst_state", state, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
